vec_feed_ctrl: RTL and testbench
================================

Name: vec_feed_ctrl

Overview:
- Upstream feeder and result collector for the Inner_Prod stage.
- Holds two VLEN-element operand vectors loaded through a random-access write port.
- On a start pulse, streams the vectors as VLEN contiguous valid beats on the Inner_Prod A/B/valid_in interface.
- Then waits a bounded time for the C/valid_out result, latches it and reports done or timeout.

Parameters:
- VLEN, 8, elements per vector; power of two, ≥2.
- DW, 8, element width in bits.
- CW, 19, result width; must be ≥ 2*DW+log2(VLEN).
- TMO, 4, cycles allowed in WAIT_RES before timeout; ≥1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the operand buffer.
- wr_sel  in  1  buffer select: 0 = vector A, 1 = vector B.
- wr_addr  in  log2(VLEN)  element index.
- wr_data  in  DW  element value.
- wr_rej  out  1  one-cycle pulse: write ignored because the block is busy.
- start  in  1  begin stream; sampled in IDLE only.
- busy  out  1  high in STREAM and WAIT_RES.
- feed_valid  out  1  drives Inner_Prod valid_in.
- feed_a  out  DW  drives Inner_Prod A.
- feed_b  out  DW  drives Inner_Prod B.
- res_valid  in  1  from Inner_Prod valid_out.
- res_data  in  CW  from Inner_Prod C.
- result  out  CW  last captured result; held until the next capture or reset.
- done  out  1  one-cycle pulse when a result is captured.
- tmo_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: FSM → IDLE. Both buffers cleared to 0. All outputs 0, including result. Reset overrides everything, including mid-stream: feed_valid drops at the next edge and no done/tmo_err is issued.
- All outputs are registered.
- FSM IDLE:
  - wr_en writes buf[wr_sel][wr_addr] at the edge.
  - start=1 → STREAM with idx=0.
  - If start and wr_en arrive in the same cycle, the write commits and start is also taken; the stream sees the new value.
- FSM STREAM:
  - First beat appears the cycle after start is sampled.
  - feed_valid=1 with feed_a=bufA[idx], feed_b=bufB[idx] for exactly VLEN consecutive cycles, idx 0..VLEN-1, no gaps.
  - After the beat with idx=VLEN-1 → WAIT_RES, and feed_valid, feed_a and feed_b return to 0 in that same next cycle.
- FSM WAIT_RES:
  - A timeout counter counts the cycles spent in this state.
  - res_valid=1 → result←res_data, done pulses the next cycle, go to IDLE.
  - TMO cycles elapse without res_valid → tmo_err pulses, result is unchanged, go to IDLE.
  - Nominal Inner_Prod delivers res_valid in the first WAIT_RES cycle.
- res_valid outside WAIT_RES is ignored; result and done are unaffected.
- wr_en while busy: write discarded, buffers unchanged, wr_rej=1 the following cycle.
- start while busy: ignored, no queuing.
- start in the same cycle the FSM returns to IDLE is not sampled; start must be high while the FSM is in IDLE.
- Buffers retain their contents across runs, so a repeated start re-streams identical data.
- busy=1 from the cycle after start through the cycle that the done or tmo_err pulse is issued; 0 afterwards.

Decomposition:
- Shared package vec_pkg: VLEN, DW and CW defaults; a derived index-width constant; FSM state enum {IDLE, STREAM, WAIT_RES}.
- Sub-module vec_buf: 2×VLEN×DW register file with synchronous reset clear, one write port and one combinational read port (shared index, dual output).
- FSM, index counter and timeout counter live in the top module.

Test Plan:
1. Reset behaviour: assert rst for one cycle → all outputs 0. Then start with buffers never written → 8 beats of feed_a=feed_b=0. Model returns 0 → result=0, done pulse.
2. Nominal run:
   - Load A={01,B2,31,15,E3,D0,FF,CB} and B={3D,15,99,A6,72,5B,4E,53}.
   - Pulse start → feed_valid high exactly 8 contiguous cycles, starting 1 cycle after start, with pairs in index order.
   - Inner_Prod model returns 19'h17847 in the first WAIT_RES cycle → result=0x17847, done pulse once, busy falls.
3. Timeout: run with the model silenced → tmo_err pulses after 4 WAIT_RES cycles, result keeps 0x17847, FSM returns to IDLE; a subsequent start is accepted.
4. Busy protection: wr_en to A[3]=0x00 and start during STREAM → wr_rej pulse, no restart. A re-run still streams A[3]=0x15 and yields 0x17847.
5. Mid-stream reset: assert rst at beat 4 → feed_valid=0 the next cycle, buffers=0, no done; a late res_valid is ignored.
6. Stray and simultaneous events:
   - res_valid=1 while IDLE → result unchanged, no done.
   - wr_en(A[0]=0x02) together with start in IDLE → first beat feed_a=0x02.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared defaults and FSM state encoding for the Inner_Prod vector feeder.
package vec_pkg;
   localparam int VEC_VLEN = 8;
   localparam int VEC_DW   = 8;
   localparam int VEC_CW   = 19;
   localparam int VEC_TMO  = 4;
   localparam int VEC_IW   = $clog2(VEC_VLEN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_RES = 2'd2
   } state_t;
endpackage

// File: rtl/vec_buf.sv
// Two-bank operand register file: one decoded write port, one shared-index read port.
module vec_buf
   import vec_pkg::*;
#(
   parameter int VLEN = VEC_VLEN,
   parameter int DW   = VEC_DW,
   parameter int AW   = VEC_IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_a,
   output logic [DW-1:0] rd_b
);

   logic [DW-1:0] mem_a [VLEN];
   logic [DW-1:0] mem_b [VLEN];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < VLEN; i++) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end
      end else if (wr_en) begin
         if (wr_sel) mem_b[wr_addr] <= wr_data;
         else        mem_a[wr_addr] <= wr_data;
      end
   end

   assign rd_a = mem_a[rd_addr];
   assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/vec_feed_ctrl.sv
// Streams two stored operand vectors into Inner_Prod and collects its result.
//
// state    | meaning
// IDLE     | buffer writable, waiting for start
// STREAM   | one A/B beat per cycle, idx 0..VLEN-1
// WAIT_RES | waiting up to TMO cycles for res_valid
module vec_feed_ctrl
   import vec_pkg::*;
#(
   parameter int VLEN = VEC_VLEN,
   parameter int DW   = VEC_DW,
   parameter int CW   = VEC_CW,
   parameter int TMO  = VEC_TMO
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [$clog2(VLEN)-1:0]  wr_addr,
   input  logic [DW-1:0]            wr_data,
   output logic                     wr_rej,
   input  logic                     start,
   output logic                     busy,
   output logic                     feed_valid,
   output logic [DW-1:0]            feed_a,
   output logic [DW-1:0]            feed_b,
   input  logic                     res_valid,
   input  logic [CW-1:0]            res_data,
   output logic [CW-1:0]            result,
   output logic                     done,
   output logic                     tmo_err
);

   localparam int AW = $clog2(VLEN);
   localparam int TW = $clog2(TMO + 1);
   localparam logic [AW-1:0] IDX_LAST = AW'(VLEN - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TMO - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] idx, idx_nxt, rd_addr;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic [DW-1:0] rd_a, rd_b, feed_a_nxt, feed_b_nxt;
   logic [CW-1:0] result_nxt;
   logic          feed_valid_nxt, done_nxt, tmo_err_nxt, busy_nxt, wr_rej_nxt;
   logic          buf_we, fwd_a, fwd_b;

   // busy also covers the done/tmo_err pulse cycle, so it gates writes and start there too
   assign buf_we  = wr_en & ~busy;
   assign rd_addr = (state == STREAM) ? idx + AW'(1) : '0;
   assign fwd_a   = buf_we & ~wr_sel & (wr_addr == '0);
   assign fwd_b   = buf_we &  wr_sel & (wr_addr == '0);

   vec_buf #(
      .VLEN (VLEN),
      .DW   (DW),
      .AW   (AW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_we),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_a    (rd_a),
      .rd_b    (rd_b)
   );

   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      tmo_nxt        = tmo_cnt;
      feed_valid_nxt = 1'b0;
      feed_a_nxt     = '0;
      feed_b_nxt     = '0;
      result_nxt     = result;
      done_nxt       = 1'b0;
      tmo_err_nxt    = 1'b0;
      wr_rej_nxt     = wr_en & busy;

      case (state)
         IDLE: begin
            if (start && !busy) begin
               state_nxt      = STREAM;
               idx_nxt        = '0;
               feed_valid_nxt = 1'b1;
               // a write to element 0 in the start cycle must reach the first beat
               feed_a_nxt     = fwd_a ? wr_data : rd_a;
               feed_b_nxt     = fwd_b ? wr_data : rd_b;
            end
         end
         STREAM: begin
            if (idx == IDX_LAST) begin
               state_nxt = WAIT_RES;
               tmo_nxt   = TMO_LOAD;
            end else begin
               idx_nxt        = idx + AW'(1);
               feed_valid_nxt = 1'b1;
               feed_a_nxt     = rd_a;
               feed_b_nxt     = rd_b;
            end
         end
         WAIT_RES: begin
            if (res_valid) begin
               result_nxt = res_data;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else if (tmo_cnt == '0) begin
               tmo_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               tmo_nxt = tmo_cnt - TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE) | done_nxt | tmo_err_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         tmo_cnt    <= '0;
         feed_valid <= 1'b0;
         feed_a     <= '0;
         feed_b     <= '0;
         result     <= '0;
         done       <= 1'b0;
         tmo_err    <= 1'b0;
         busy       <= 1'b0;
         wr_rej     <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         tmo_cnt    <= tmo_nxt;
         feed_valid <= feed_valid_nxt;
         feed_a     <= feed_a_nxt;
         feed_b     <= feed_b_nxt;
         result     <= result_nxt;
         done       <= done_nxt;
         tmo_err    <= tmo_err_nxt;
         busy       <= busy_nxt;
         wr_rej     <= wr_rej_nxt;
      end
   end

endmodule

// File: tb/tb_vec_feed_ctrl.sv
// Scoreboard bench for vec_feed_ctrl with a behavioural Inner_Prod responder.
module tb_vec_feed_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, wr_sel, start;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_rej, busy, feed_valid, done, tmo_err;
   logic [7:0]  feed_a, feed_b;
   logic        res_valid;
   logic [18:0] res_data, result;

   logic        mdl_valid = 1'b0, stray_valid = 1'b0;
   logic [18:0] mdl_data = '0, stray_data = '0;
   assign res_valid = mdl_valid | stray_valid;
   assign res_data  = mdl_valid ? mdl_data : stray_data;

   vec_feed_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_rej     (wr_rej),
      .start      (start),
      .busy       (busy),
      .feed_valid (feed_valid),
      .feed_a     (feed_a),
      .feed_b     (feed_b),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .result     (result),
      .done       (done),
      .tmo_err    (tmo_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, beat_base = 0, done_seen = 0, tmo_seen = 0;
   logic [15:0] beat_q [$];
   int          res_q  [$];
   logic [7:0]  ma [8], mb [8];
   bit          model_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int dot();
      int s = 0;
      for (int i = 0; i < 8; i++) s += int'(ma[i]) * int'(mb[i]);
      return s;
   endfunction

   // Inner_Prod stand-in: accumulates observed beats, answers in the first WAIT_RES cycle
   int          m_acc = 0, m_cnt = 0;
   bit          m_pend = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         m_acc = 0; m_cnt = 0; m_pend = 1'b0; mdl_valid = 1'b0;
      end else begin
         mdl_valid = 1'b0;
         if (m_pend) begin
            mdl_valid = 1'b1;
            m_pend    = 1'b0;
         end
         if (feed_valid) begin
            m_acc += int'(feed_a) * int'(feed_b);
            m_cnt++;
            if (m_cnt == 8) begin
               m_pend   = model_en;
               mdl_data = m_acc[18:0];
               m_acc    = 0;
               m_cnt    = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (feed_valid) begin
            if (beat_q.size() == 0) begin
               check("extra_beat", 32'(feed_valid), 32'd0);
            end else begin
               int bi;
               logic [15:0] eb;
               bi = 8 - beat_q.size();
               eb = beat_q.pop_front();
               check("beat_data", 32'({feed_a, feed_b}), 32'(eb));
               check("beat_cycle", 32'(cyc - beat_base), 32'(bi + 1));
            end
         end
         if (done) begin
            done_seen++;
            if (res_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
            else                   check("result", 32'(result), 32'(res_q.pop_front()));
         end
         if (tmo_err) tmo_seen++;
      end
   end

   task automatic wr(input bit sel, input int addr, input logic [7:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr[2:0]; wr_data = data;
      if (sel) mb[addr] = data; else ma[addr] = data;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_start(input bit exp_done, input bit with_wr, input bit sel,
                           input int addr, input logic [7:0] data);
      if (with_wr) begin
         wr_en = 1'b1; wr_sel = sel; wr_addr = addr[2:0]; wr_data = data;
         if (sel) mb[addr] = data; else ma[addr] = data;
      end
      start     = 1'b1;
      beat_base = cyc;
      done_seen = 0;
      tmo_seen  = 0;
      for (int i = 0; i < 8; i++) beat_q.push_back({ma[i], mb[i]});
      if (exp_done) res_q.push_back(dot());
      step();
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   // returns the cycle the done/tmo_err pulse was seen, leaves the bench one cycle later
   task automatic wait_end(output int at);
      at = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || tmo_err) begin
            at = cyc;
            check("busy_in_pulse", 32'(busy), 32'd1);
            break;
         end
      end
      if (at < 0) check("end_wait_expired", 32'd0, 32'd1);
      step();
      @(negedge clk);
      check("busy_after_pulse", 32'(busy), 32'd0);
      check("pulse_one_cycle", 32'(done | tmo_err), 32'd0);
      check("beats_consumed", 32'(beat_q.size()), 32'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish within 100us");
      $fatal(1);
   end

   logic [7:0] a_init [8] = '{8'h01, 8'hB2, 8'h31, 8'h15, 8'hE3, 8'hD0, 8'hFF, 8'hCB};
   logic [7:0] b_init [8] = '{8'h3D, 8'h15, 8'h99, 8'hA6, 8'h72, 8'h5B, 8'h4E, 8'h53};
   int at;

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; end
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_outputs", 32'({feed_valid, busy, done, tmo_err, wr_rej}), 32'd0);
      check("rst_feed", 32'({feed_a, feed_b}), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      step();

      // never-written buffers stream zeros
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      check("zero_run_done", 32'(done_seen), 32'd1);

      // nominal
      for (int i = 0; i < 8; i++) wr(1'b0, i, a_init[i]);
      for (int i = 0; i < 8; i++) wr(1'b1, i, b_init[i]);
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      @(negedge clk);
      check("busy_in_stream", 32'(busy), 32'd1);
      step();
      wait_end(at);
      check("nom_done_cycle", 32'(at - beat_base), 32'd10);
      check("nom_result", 32'(result), 32'h17847);
      check("nom_done_count", 32'(done_seen), 32'd1);

      // timeout with responder silenced
      model_en = 1'b0;
      do_start(1'b0, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      model_en = 1'b1;
      check("tmo_cycle", 32'(at - beat_base), 32'd13);
      check("tmo_count", 32'(tmo_seen), 32'd1);
      check("tmo_no_done", 32'(done_seen), 32'd0);
      check("tmo_result_held", 32'(result), 32'h17847);
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      check("restart_after_tmo", 32'(done_seen), 32'd1);

      // write and start while streaming are both dropped
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      step(); step();
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd3; wr_data = 8'h00; start = 1'b1;
      step();
      wr_en = 1'b0; start = 1'b0;
      @(negedge clk);
      check("wr_rej_pulse", 32'(wr_rej), 32'd1);
      step();
      wait_end(at);
      check("busy_run_done", 32'(done_seen), 32'd1);
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      check("rerun_result", 32'(result), 32'h17847);

      // mid-stream reset at beat 4
      do_start(1'b0, 1'b0, 1'b0, 0, 8'h00);
      step(); step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      beat_q.delete();
      for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; end
      @(negedge clk);
      check("rst_mid_feed_valid", 32'(feed_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      step();
      stray_valid = 1'b1; stray_data = 19'h5A5A5;
      step();
      stray_valid = 1'b0;
      step(); step(); step(); step(); step();
      @(negedge clk);
      check("late_res_result", 32'(result), 32'd0);
      check("late_res_no_done", 32'(done_seen), 32'd0);
      step();
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      check("cleared_buf_result", 32'(result), 32'd0);

      // stray res_valid in IDLE, then write+start in the same cycle
      for (int i = 0; i < 8; i++) wr(1'b0, i, a_init[i]);
      for (int i = 0; i < 8; i++) wr(1'b1, i, b_init[i]);
      do_start(1'b1, 1'b0, 1'b0, 0, 8'h00);
      wait_end(at);
      done_seen = 0;
      stray_valid = 1'b1; stray_data = 19'h12345;
      step();
      stray_valid = 1'b0;
      @(negedge clk);
      check("stray_result", 32'(result), 32'h17847);
      check("stray_no_done", 32'(done_seen), 32'd0);
      step();
      do_start(1'b1, 1'b1, 1'b0, 0, 8'h02);
      wait_end(at);
      check("wr_start_result", 32'(result), 32'h17884);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
